// File: rtl/probe_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : probe_sel_ctrl_if
// Description : Request handshake and select outputs of the probe select ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface probe_sel_ctrl_if #(
    parameter int N  = 4,
    parameter int CW = 2
);
    logic          req_valid;
    logic [CW-1:0] req_chan;
    logic          req_ready;
    logic          scan_en;
    logic [N-1:0]  sw;
    logic [CW-1:0] cur_chan;
    logic          sel_valid;

    modport master (
        output req_valid, req_chan, scan_en,
        input  req_ready, sw, cur_chan, sel_valid
    );

    modport slave (
        input  req_valid, req_chan, scan_en,
        output req_ready, sw, cur_chan, sel_valid
    );
endinterface
`default_nettype wire

// File: rtl/probe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : probe_sel_ctrl
// Description : Break-before-make one-hot probe mux select with request
//               handshake. Optional auto-scan: PROBE_SEL_AUTOSCAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module probe_sel_ctrl #(
    parameter int N     = 4,
    parameter int CW    = 2,
    parameter int GUARD = 2,
    parameter int DWELL = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    probe_sel_ctrl_if.slave   bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GUARD  = 2'd1;
    localparam logic [1:0] c_ACTIVE = 2'd2;

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GW-1:0] c_GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam logic [CW:0]   c_N          = (CW + 1)'(N);
    localparam logic [N-1:0]  c_ONE        = N'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] cur_chan_q, cur_chan_d;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
    logic [N-1:0]  sw_q, sw_d;
    logic          sel_valid_q, sel_valid_d;
    logic          req_ready_q, req_ready_d;

    logic          w_accept;
    logic          w_chan_on;
    logic          w_go;
    logic [CW-1:0] w_go_chan;

    assign w_accept  = bus.req_valid && req_ready_q;
    assign w_chan_on = {1'b0, bus.req_chan} < c_N;

`ifdef PROBE_SEL_AUTOSCAN_EN
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] c_DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] c_LAST_CHAN  = CW'(N - 1);

    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CW-1:0] w_next_chan;

    assign w_next_chan = (cur_chan_q == c_LAST_CHAN) ? '0 : cur_chan_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_cnt_q <= '0;
        end else begin
            dwell_cnt_q <= dwell_cnt_d;
        end
    end
`else
    logic unused_scan_en;
    assign unused_scan_en = bus.scan_en;
`endif

    // State register; all outputs are registered from next-state values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            target_q    <= '0;
            cur_chan_q  <= '0;
            guard_cnt_q <= '0;
            sw_q        <= '0;
            sel_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cur_chan_q  <= cur_chan_d;
            guard_cnt_q <= guard_cnt_d;
            sw_q        <= sw_d;
            sel_valid_q <= sel_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cur_chan_d  = cur_chan_q;
        guard_cnt_d = '0;
        w_go        = 1'b0;
        w_go_chan   = bus.req_chan;
`ifdef PROBE_SEL_AUTOSCAN_EN
        dwell_cnt_d = '0;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    w_go = w_chan_on;
`ifdef PROBE_SEL_AUTOSCAN_EN
                end else if (bus.scan_en) begin
                    w_go      = 1'b1;
                    w_go_chan = '0;
`endif
                end
            end
            c_GUARD: begin
                if (guard_cnt_q == c_GUARD_LAST) begin
                    state_d    = c_ACTIVE;
                    cur_chan_d = target_q;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            c_ACTIVE: begin
                // A request always wins over a dwell expiry in the same cycle.
                if (w_accept) begin
                    if (!w_chan_on) begin
                        state_d = c_IDLE;
                    end else if (bus.req_chan != cur_chan_q) begin
                        w_go = 1'b1;
                    end
`ifdef PROBE_SEL_AUTOSCAN_EN
                end else if (bus.scan_en) begin
                    if (dwell_cnt_q == c_DWELL_LAST) begin
                        w_go      = 1'b1;
                        w_go_chan = w_next_chan;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DW'(1);
                    end
`endif
                end
            end
            default: state_d = c_IDLE;
        endcase

        if (w_go) begin
            target_d = w_go_chan;
            if (GUARD == 0) begin
                state_d    = c_ACTIVE;
                cur_chan_d = w_go_chan;
            end else begin
                state_d = c_GUARD;
            end
        end
    end

    always_comb begin
        sw_d        = '0;
        sel_valid_d = 1'b0;
        req_ready_d = (state_d != c_GUARD);
        if (state_d == c_ACTIVE) begin
            sw_d        = c_ONE << cur_chan_d;
            sel_valid_d = 1'b1;
        end
    end

    assign bus.sw        = sw_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.req_ready = req_ready_q;
    assign bus.cur_chan  = cur_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_probe_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_probe_sel_ctrl
// Description : Directed and randomized self-checking bench for probe_sel_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_probe_sel_ctrl;
    localparam int N     = 4;
    localparam int CW    = 3;
    localparam int DWELL = 4;
`ifdef PROBE_SEL_AUTOSCAN_EN
    localparam int GUARD = 1;
    localparam bit AUTO  = 1'b1;
`else
    localparam int GUARD = 2;
    localparam bit AUTO  = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    probe_sel_ctrl_if #(.N(N), .CW(CW)) bus ();

    probe_sel_ctrl #(.N(N), .CW(CW), .GUARD(GUARD), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: which channel is wanted, how many blank cycles remain.
    int m_on, m_chan, m_zero, m_dwell;

    task automatic model_reset();
        m_on = 0; m_chan = 0; m_zero = 0; m_dwell = 0;
    endtask

    task automatic model_step(input bit acc, input int ch, input bit scan);
        if (m_zero > 0) begin
            m_zero--;
            m_dwell = 0;
        end else if (acc) begin
            m_dwell = 0;
            if (ch >= N) m_on = 0;
            else if (!(m_on == 1 && ch == m_chan)) begin
                m_on = 1; m_chan = ch; m_zero = GUARD;
            end
        end else if (AUTO && scan) begin
            if (m_on == 0) begin
                m_on = 1; m_chan = 0; m_zero = GUARD; m_dwell = 0;
            end else begin
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_dwell = 0; m_chan = (m_chan + 1) % N; m_zero = GUARD;
                end
            end
        end else begin
            m_dwell = 0;
        end
    endtask

    task automatic drive(input bit v, input int ch, input bit s);
        bus.req_valid = v;
        bus.req_chan  = CW'(ch);
        bus.scan_en   = s;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0);
        step();
        step();
        checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL reset_sw: got %b want 0000", bus.sw); end
        checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_sel_valid: got %b want 0", bus.sel_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.cur_chan !== 3'd0) begin errors++; $display("FAIL reset_cur_chan: got %0d want 0", bus.cur_chan); end
        rst_n = 1'b1;
    endtask

    task automatic test_switch();
        drive(1, 2, 0);
        step();
        drive(0, 0, 0);
        for (int g = 0; g < GUARD; g++) begin
            checks++; if (bus.sw !== 4'b0000 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL switch_guard%0d: sw=%b ready=%b want 0000/0", g, bus.sw, bus.req_ready); end
            step();
        end
        checks++; if (bus.sw !== 4'b0100) begin errors++; $display("FAIL switch_sw: got %b want 0100", bus.sw); end
        checks++; if (bus.sel_valid !== 1'b1 || bus.cur_chan !== 3'd2) begin errors++; $display("FAIL switch_live: valid=%b chan=%0d want 1/2", bus.sel_valid, bus.cur_chan); end
    endtask

    task automatic test_same_and_change();
        drive(1, 2, 0);
        step();
        drive(0, 0, 0);
        checks++; if (bus.sw !== 4'b0100 || bus.sel_valid !== 1'b1) begin errors++; $display("FAIL same_chan: sw=%b valid=%b want 0100/1", bus.sw, bus.sel_valid); end
        drive(1, 3, 0);
        step();
        drive(0, 0, 0);
        for (int g = 0; g < GUARD; g++) begin
            checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL change_guard%0d: got %b want 0000", g, bus.sw); end
            step();
        end
        checks++; if (bus.sw !== 4'b1000 || bus.cur_chan !== 3'd3) begin errors++; $display("FAIL change_live: sw=%b chan=%0d want 1000/3", bus.sw, bus.cur_chan); end
    endtask

    task automatic test_stall_and_off();
        drive(1, 1, 0);
        step();
        drive(1, 0, 0);
        for (int g = 0; g < GUARD; g++) begin
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", g, bus.req_ready); end
            step();
        end
        checks++; if (bus.sw !== 4'b0010 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL stall_active: sw=%b ready=%b want 0010/1", bus.sw, bus.req_ready); end
        step();
        drive(0, 0, 0);
        for (int g = 0; g < GUARD; g++) begin
            checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL stall_guard%0d: got %b want 0000", g, bus.sw); end
            step();
        end
        checks++; if (bus.sw !== 4'b0001) begin errors++; $display("FAIL stall_accepted: got %b want 0001", bus.sw); end
        drive(1, 4, 0);
        step();
        drive(0, 0, 0);
        checks++; if (bus.sw !== 4'b0000 || bus.sel_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL off_req: sw=%b valid=%b ready=%b want 0000/0/1", bus.sw, bus.sel_valid, bus.req_ready); end
        step();
        checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL off_hold: got %b want 0000", bus.sw); end
    endtask

    task automatic test_reset_mid_guard();
        drive(1, 1, 0);
        step();
        drive(0, 0, 0);
        checks++; if (bus.sw !== 4'b0000 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL rguard_entry: sw=%b ready=%b want 0000/0", bus.sw, bus.req_ready); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.sw !== 4'b0000 || bus.sel_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rguard_reset: sw=%b valid=%b ready=%b want 0000/0/1", bus.sw, bus.sel_valid, bus.req_ready); end
        for (int k = 0; k < GUARD + 2; k++) begin
            step();
            checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL rguard_after%0d: got %b want 0000", k, bus.sw); end
        end
    endtask

`ifdef PROBE_SEL_AUTOSCAN_EN
    task automatic test_autoscan();
        logic [3:0] exp_sw;
        drive(0, 0, 1);
        step();
        for (int c = 0; c <= N; c++) begin
            for (int g = 0; g < GUARD; g++) begin
                checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL scan_guard_c%0d: got %b want 0000", c, bus.sw); end
                step();
            end
            exp_sw = 4'(1) << (c % N);
            if (c == N) break;
            for (int d = 0; d < DWELL; d++) begin
                checks++; if (bus.sw !== exp_sw) begin errors++; $display("FAIL scan_dwell_c%0d_%0d: got %b want %b", c, d, bus.sw, exp_sw); end
                step();
            end
        end
        checks++; if (bus.sw !== 4'b0001) begin errors++; $display("FAIL scan_wrap: got %b want 0001", bus.sw); end
        for (int k = 2; k <= DWELL; k++) begin
            step();
            checks++; if (bus.sw !== 4'b0001) begin errors++; $display("FAIL scan_hold%0d: got %b want 0001", k, bus.sw); end
        end
        drive(1, 2, 1);
        step();
        drive(0, 0, 1);
        for (int g = 0; g < GUARD; g++) begin
            checks++; if (bus.sw !== 4'b0000) begin errors++; $display("FAIL scan_prio_guard: got %b want 0000", bus.sw); end
            step();
        end
        checks++; if (bus.sw !== 4'b0100 || bus.cur_chan !== 3'd2) begin errors++; $display("FAIL scan_prio: sw=%b chan=%0d want 0100/2", bus.sw, bus.cur_chan); end
        drive(0, 0, 0);
    endtask
`endif

    task automatic test_random();
        bit         v, s, acc;
        int         ch;
        logic [3:0] e_sw;
        rst_n = 1'b0;
        drive(0, 0, 0);
        step();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 2) != 0);
            ch  = $urandom_range(0, N);
            s   = ($urandom_range(0, 3) != 0);
            drive(v, ch, s);
            acc = v && (m_zero == 0);
            @(posedge clk);
            model_step(acc, ch, s);
            @(negedge clk);
            e_sw = (m_on == 1 && m_zero == 0) ? (4'(1) << m_chan) : 4'b0000;
            checks++; if (bus.sw !== e_sw) begin errors++; $display("FAIL rand_sw@%0d: got %b want %b", i, bus.sw, e_sw); end
            checks++; if (bus.sel_valid !== (e_sw != 4'b0000)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", i, bus.sel_valid, e_sw != 4'b0000); end
            checks++; if (bus.req_ready !== (m_zero == 0)) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", i, bus.req_ready, m_zero == 0); end
            if (e_sw != 4'b0000) begin
                checks++; if (bus.cur_chan !== CW'(m_chan)) begin errors++; $display("FAIL rand_chan@%0d: got %0d want %0d", i, bus.cur_chan, m_chan); end
            end
        end
        drive(0, 0, 0);
    endtask

    initial begin
        drive(0, 0, 0);
        @(negedge clk);
        test_reset();
        test_switch();
        test_same_and_change();
        test_stall_and_off();
        test_reset_mid_guard();
`ifdef PROBE_SEL_AUTOSCAN_EN
        test_autoscan();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
